// File: rtl/stream_burst_source.sv
// stream_burst_source
//   Emits bursts of incrementing data beats on a valid/ready stream.
//   A burst is requested with a start pulse while idle. Its length, the
//   number of idle cycles after each accepted non-final beat, and the
//   value of beat 0 are captured at that moment. Beat i carries
//   (seed + i) mod 2^DATA_WIDTH. A burst can be cut short with abort.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    burst request, only honoured while idle
//   burst_len                beats in the burst (0 = empty burst)
//   gap_cycles               idle cycles after each accepted non-final beat
//   seed                     value of beat 0
//   abort                    end the burst early
//   out_valid/out_ready      stream handshake
//   out_data, out_last       beat payload and final-beat marker
//   busy                     not idle
//   done, aborted            end-of-burst pulse and its "ended by abort" flag
//   beat_count               beats accepted in the current/most recent burst
module stream_burst_source #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic [GAP_WIDTH-1:0]  gap_cycles,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  beat_count
);

    typedef enum logic [1:0] {IDLE, SEND, GAP, FIN} state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);

    state_t                state, state_nxt;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [GAP_WIDTH-1:0]  gap_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [GAP_WIDTH-1:0]  gap_cnt;
    logic [LEN_WIDTH-1:0]  beat_cnt;
    logic                  abort_pend;
    logic                  aborted_q;

    logic is_last;
    logic stop_req;

    // beat_cnt doubles as the index of the beat currently presented
    assign is_last  = (beat_cnt == len_q - LEN_ONE);
    // an abort seen while a beat is pending (now or earlier) ends the burst
    // once that beat has been accepted
    assign stop_req = abort_pend | abort;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (burst_len == '0) ? FIN : SEND;
            SEND: if (out_ready) begin
                if (is_last || stop_req) state_nxt = FIN;
                else if (gap_q != '0)    state_nxt = GAP;
            end
            GAP:  begin
                if (abort)                 state_nxt = FIN;
                else if (gap_cnt == GAP_ONE) state_nxt = SEND;
            end
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q      <= '0;
            gap_q      <= '0;
            seed_q     <= '0;
            gap_cnt    <= '0;
            beat_cnt   <= '0;
            abort_pend <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    len_q      <= burst_len;
                    gap_q      <= gap_cycles;
                    seed_q     <= seed;
                    beat_cnt   <= '0;
                    abort_pend <= 1'b0;
                    aborted_q  <= 1'b0;
                end
                SEND: begin
                    if (abort) abort_pend <= 1'b1;
                    if (out_ready) begin
                        beat_cnt <= beat_cnt + LEN_ONE;
                        gap_cnt  <= gap_q;
                        if (is_last || stop_req) aborted_q <= stop_req;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - GAP_ONE;
                    if (abort) aborted_q <= 1'b1;
                end
                FIN: abort_pend <= 1'b0;
                default: ;
            endcase
        end
    end

    // Outputs depend only on registered state, so a presented beat cannot
    // change until the handshake completes.
    assign out_valid  = (state == SEND);
    assign out_data   = out_valid ? seed_q + DATA_WIDTH'(beat_cnt) : '0;
    assign out_last   = out_valid && is_last;
    assign busy       = (state != IDLE);
    assign done       = (state == FIN);
    assign aborted    = aborted_q;
    assign beat_count = beat_cnt;

endmodule

// File: tb/tb_stream_burst_source.sv
module tb_stream_burst_source;

    localparam int DW = 32;
    localparam int LW = 6;
    localparam int GW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic [GW-1:0] gap_cycles = '0;
    logic [DW-1:0] seed = '0;
    logic          abort = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] beat_count;

    int errors = 0;
    int checks = 0;

    stream_burst_source #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .GAP_WIDTH(GW)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
        .gap_cycles(gap_cycles), .seed(seed), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .aborted(aborted),
        .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    // outputs are sampled and inputs driven 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a burst is the beat list seed+0 .. seed+len-1; after each
    // accepted non-final beat the stream is silent for exactly gap cycles;
    // done follows the cycle after the last accepted beat (or after start
    // when len=0). An abort ends the burst after the beat it was seen on,
    // or immediately when seen during a gap.
    task automatic run_burst(input logic [DW-1:0] sd, input int len, input int gap,
                             input int ready_pct, input int abort_beat,
                             input bit noise, output int span);
        int k, gap_left, first_cyc;
        bit ab, done_next, fin;
        logic [DW-1:0] exp_d;
        k = 0; gap_left = 0; ab = 0; first_cyc = -1; span = -1; fin = 0;
        start = 1; burst_len = len[LW-1:0]; gap_cycles = gap[GW-1:0]; seed = sd;
        tick();
        start = 0;
        done_next = (len == 0);
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (done_next) begin
                checks++;
                if (done !== 1'b1 || aborted !== ab || out_valid !== 1'b0 || beat_count !== k[LW-1:0]) begin
                    errors++;
                    $display("FAIL burst_done: done=%b aborted=%b valid=%b count=%0d exp done=1 aborted=%b valid=0 count=%0d",
                             done, aborted, out_valid, beat_count, ab, k);
                end
                if (first_cyc >= 0) span = cyc - first_cyc;
                start = 0; abort = 0; out_ready = 0;
                tick();
                checks++;
                if (done !== 1'b0 || busy !== 1'b0 || aborted !== ab || beat_count !== k[LW-1:0]) begin
                    errors++;
                    $display("FAIL burst_idle: done=%b busy=%b aborted=%b count=%0d exp 0 0 %b %0d",
                             done, busy, aborted, beat_count, ab, k);
                end
                fin = 1;
            end else begin
                if (gap_left > 0) begin
                    checks++;
                    if (out_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                        errors++;
                        $display("FAIL gap_cycle: valid=%b busy=%b done=%b exp 0 1 0 (beat %0d)", out_valid, busy, done, k);
                    end
                    gap_left--;
                    out_ready = 1'($urandom);
                    abort = noise && ($urandom_range(19) == 0);
                    if (abort) begin ab = 1; done_next = 1; gap_left = 0; end
                end else begin
                    if (first_cyc < 0) first_cyc = cyc;
                    exp_d = sd + DW'(k);
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== exp_d || out_last !== (k == len - 1)
                        || done !== 1'b0 || beat_count !== k[LW-1:0]) begin
                        errors++;
                        $display("FAIL beat: valid=%b data=%h last=%b done=%b count=%0d exp 1 %h %b 0 %0d",
                                 out_valid, out_data, out_last, done, beat_count, exp_d, (k == len - 1), k);
                    end
                    out_ready = ($urandom_range(99) < ready_pct);
                    abort = (k == abort_beat) && !ab;
                    if (abort) ab = 1;
                    if (out_ready) begin
                        k++;
                        if (k == len || ab) done_next = 1;
                        else gap_left = gap;
                    end
                end
                if (noise) begin
                    start = 1'($urandom); burst_len = LW'($urandom);
                    gap_cycles = GW'($urandom); seed = $urandom;
                end
                tick();
            end
        end
        if (!fin) begin
            errors++;
            $display("FAIL burst_timeout: no done within budget, beats=%0d exp %0d", k, len);
        end
        start = 0; abort = 0; out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        checks++;
        if ({out_valid, out_last, busy, done, aborted} !== 5'b0 || out_data !== '0 || beat_count !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b last=%b busy=%b done=%b aborted=%b data=%h count=%0d exp all 0",
                     out_valid, out_last, busy, done, aborted, out_data, beat_count);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_gapless();
        int span;
        abort = 1; tick(); abort = 0;   // ignored while idle
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_abort: busy=%b done=%b exp 0 0", busy, done);
        end
        run_burst(32'h10, 4, 0, 100, -1, 0, span);
        checks++;
        if (span !== 4) begin
            errors++;
            $display("FAIL gapless_span: got %0d cycles exp 4", span);
        end
    endtask

    task automatic test_gap();
        int span;
        run_burst($urandom, 3, 2, 100, -1, 0, span);
        checks++;
        if (span !== 7) begin
            errors++;
            $display("FAIL gap_span: got %0d cycles exp 7", span);
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] s;
        s = $urandom;
        start = 1; burst_len = 4; gap_cycles = 0; seed = s; out_ready = 1;
        tick(); start = 0;
        tick();   // beat 0 accepted
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== s + 32'd1 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: valid=%b data=%h last=%b exp 1 %h 0", out_valid, out_data, out_last, s + 32'd1);
            end
            tick();
        end
        out_ready = 1;
        for (int b = 1; b < 4; b++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== s + DW'(b) || out_last !== (b == 3)) begin
                errors++;
                $display("FAIL stall_resume: valid=%b data=%h last=%b exp 1 %h %b", out_valid, out_data, out_last, s + DW'(b), (b == 3));
            end
            tick();
        end
        out_ready = 0;
        checks++;
        if (done !== 1'b1 || beat_count !== 6'd4 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL stall_done: done=%b count=%0d aborted=%b exp 1 4 0", done, beat_count, aborted);
        end
        tick();
    endtask

    task automatic test_wrap();
        int span;
        run_burst(32'hFFFF_FFFE, 3, 0, 100, -1, 0, span);
    endtask

    task automatic test_abort();
        logic [DW-1:0] s;
        s = $urandom;
        start = 1; burst_len = 8; gap_cycles = 0; seed = s; out_ready = 1;
        tick(); start = 0;
        tick(); tick();   // beats 0 and 1 accepted
        out_ready = 0; abort = 1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== s + 32'd2 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL abort_hold: valid=%b data=%h last=%b exp 1 %h 0", out_valid, out_data, out_last, s + 32'd2);
            end
            tick();
            abort = 0;
        end
        out_ready = 1;
        tick();
        out_ready = 0;
        checks++;
        if (done !== 1'b1 || aborted !== 1'b1 || beat_count !== 6'd3 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_done: done=%b aborted=%b count=%0d valid=%b exp 1 1 3 0", done, aborted, beat_count, out_valid);
        end
        tick();
        checks++;
        if (done !== 1'b0 || aborted !== 1'b1 || beat_count !== 6'd3) begin
            errors++;
            $display("FAIL abort_hold_idle: done=%b aborted=%b count=%0d exp 0 1 3", done, aborted, beat_count);
        end
    endtask

    task automatic test_abort_gap();
        start = 1; burst_len = 5; gap_cycles = 4; seed = $urandom; out_ready = 1;
        tick(); start = 0;
        tick();   // beat 0 accepted, now in gap
        abort = 1;
        tick();
        abort = 0; out_ready = 0;
        checks++;
        if (done !== 1'b1 || aborted !== 1'b1 || beat_count !== 6'd1) begin
            errors++;
            $display("FAIL gap_abort: done=%b aborted=%b count=%0d exp 1 1 1", done, aborted, beat_count);
        end
        tick();
    endtask

    task automatic test_zero_len();
        int span;
        run_burst($urandom, 0, 3, 100, -1, 0, span);
    endtask

    task automatic test_max_len();
        int span;
        run_burst($urandom, 63, 0, 100, -1, 0, span);
        checks++;
        if (span !== 63) begin
            errors++;
            $display("FAIL max_len_span: got %0d cycles exp 63", span);
        end
    endtask

    task automatic test_reset_mid();
        int span;
        start = 1; burst_len = 6; gap_cycles = 0; seed = $urandom; out_ready = 1;
        tick(); start = 0;
        tick();
        out_ready = 0; abort = 1;
        tick();
        abort = 0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: valid=%b busy=%b exp 1 1", out_valid, busy);
        end
        rst = 1;
        tick();
        rst = 0;
        checks++;
        if ({out_valid, out_last, busy, done, aborted} !== 5'b0 || out_data !== '0 || beat_count !== '0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b last=%b busy=%b done=%b aborted=%b data=%h count=%0d exp all 0",
                     out_valid, out_last, busy, done, aborted, out_data, beat_count);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet: done=%b busy=%b exp 0 0", done, busy);
            end
        end
        out_ready = 0;
        // pending abort must not leak into the next burst
        run_burst($urandom, 5, 1, 100, -1, 0, span);
    endtask

    task automatic test_random();
        int span, len, ab;
        for (int n = 0; n < 25; n++) begin
            len = $urandom_range(12);
            ab  = ($urandom_range(2) == 0) ? int'($urandom_range(12)) : -1;
            run_burst($urandom, len, $urandom_range(3), $urandom_range(100, 30), ab, 1, span);
            for (int i = $urandom_range(2); i > 0; i--) tick();
        end
    endtask

    initial begin
        test_reset();
        test_gapless();
        test_gap();
        test_stall();
        test_wrap();
        test_abort();
        test_abort_gap();
        test_zero_len();
        test_max_len();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_burst_source.md
STREAM_BURST_SOURCE -- requirements
Module: stream_burst_source

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of out_data and seed.
REQ-002 SHALL have parameter LEN_WIDTH, default 16: width of burst_len and beat_count.
REQ-003 SHALL have parameter GAP_WIDTH, default 8: width of gap_cycles.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port start, input, 1: burst request pulse, sampled only in IDLE.
REQ-007 SHALL have port burst_len, input, LEN_WIDTH: number of beats in the burst, latched at start.
REQ-008 SHALL have port gap_cycles, input, GAP_WIDTH: idle cycles inserted after each accepted non-final beat, latched at start.
REQ-009 SHALL have port seed, input, DATA_WIDTH: data value of beat 0, latched at start.
REQ-010 SHALL have port abort, input, 1: request to end the burst early.
REQ-011 SHALL have port out_valid, output, 1: beat available.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the beat.
REQ-013 SHALL have port out_data, output, DATA_WIDTH: beat payload.
REQ-014 SHALL have port out_last, output, 1: final beat of the burst.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle pulse at burst end.
REQ-017 SHALL have port aborted, output, 1: qualifies done; high if the burst ended by abort.
REQ-018 SHALL have port beat_count, output, LEN_WIDTH: beats accepted in the current or most recent burst.

Function
REQ-019 SHALL implement FSM states IDLE, SEND, GAP and FIN.
REQ-020 SHALL treat a beat as transferred only in a cycle with out_valid=1 and out_ready=1.
REQ-021 In IDLE, start=1 SHALL latch burst_len, gap_cycles and seed, clear beat_count and aborted, and go to SEND, or to FIN if burst_len=0.
REQ-022 In SEND, out_valid SHALL be 1, out_data SHALL be (seed + beat index) mod 2^DATA_WIDTH, and out_last SHALL be 1 when beat index = latched burst_len-1.
REQ-023 Once out_valid is asserted, out_valid, out_data and out_last SHALL stay stable until the beat is transferred, regardless of out_ready or abort.
REQ-024 On a transfer in SEND, beat_count SHALL increment in the same edge.
REQ-025 On a non-final transfer with latched gap=0, the FSM SHALL stay in SEND and present the next beat in the next cycle, giving 1 beat/cycle throughput.
REQ-026 On a non-final transfer with latched gap=G>0, the FSM SHALL spend exactly G cycles in GAP with out_valid=0, then return to SEND.
REQ-027 The final transfer (out_last=1) SHALL move the FSM to FIN.
REQ-028 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-029 Latency SHALL be: first out_valid in the cycle after start is sampled; done one cycle after the final transfer.
REQ-030 abort=1 in SEND SHALL be recorded; the pending beat completes unchanged, then the FSM goes to FIN with aborted=1.
REQ-031 abort=1 in GAP SHALL move the FSM to FIN in the next cycle with aborted=1.
REQ-032 abort SHALL be ignored in IDLE and FIN.
REQ-033 start SHALL be ignored outside IDLE, including start and abort asserted in the same cycle.
REQ-034 Data values SHALL wrap modulo 2^DATA_WIDTH without any flag.
REQ-035 burst_len at its maximum value (all ones) SHALL produce exactly 2^LEN_WIDTH-1 beats.
REQ-036 beat_count and aborted SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-037 With rst=1 at a clock edge, the block SHALL enter IDLE with out_valid=0, out_last=0, out_data=0, busy=0, done=0, aborted=0, beat_count=0, clearing any pending abort.
REQ-038 Reset SHALL take priority over all other inputs, including mid-burst and during a stalled beat; no done pulse SHALL follow reset.

Verification
REQ-039 Bench SHALL cover: seed=0x10, len=4, gap=0, out_ready=1 -> data 0x10,0x11,0x12,0x13 on consecutive cycles; out_last on 0x13; done 1 cycle later; beat_count=4.
REQ-040 Bench SHALL cover: len=3, gap=2, out_ready=1 -> each beat followed by 2 cycles of out_valid=0, none after the last; 7 cycles from first out_valid to done.
REQ-041 Bench SHALL cover: out_ready held low 5 cycles on beat 1 -> out_valid/out_data stay at seed+1 for all 5 cycles; no beat lost or duplicated.
REQ-042 Bench SHALL cover: seed=0xFFFFFFFE, len=3 -> data 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-043 Bench SHALL cover: len=8, abort pulsed while beat 2 is stalled -> beat 2 completes, done with aborted=1, beat_count=3; a separate run with len=0 -> no out_valid and done in the cycle after start.
REQ-044 Bench SHALL cover: rst asserted mid-burst with a beat stalled -> all outputs reach their reset values next cycle and no done pulse occurs.
